filter_pair_feeder: RTL and testbench

- Source side of the pair-filter interface. For one home cell and one neighbour cell it walks home particle i (outer loop) against neighbour particle j (inner loop).
- Reads positions from the home and neighbour position caches and presents each candidate pair (x1,y1,z1 = home; x2,y2,z2 = neighbour) to the filter bank.
- Pairs leave over a valid/ready handshake and carry index tags, so accepted pairs can be routed to the force pipeline.

---
 rtl/filter_pair_feeder.sv | 173 +++++++++++++++++
 tb/tb_filter_pair_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_pair_feeder.sv
// Streams (home i, neighbour j) particle pairs from two position caches to the
// pair-filter bank over valid/ready, tagging each pair with its indices.
module filter_pair_feeder #(
  parameter int MAX_PARTICLES = 64,
  parameter int IDX_W         = $clog2(MAX_PARTICLES),
  parameter int COORD_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [IDX_W:0]         home_count,
  input  logic [IDX_W:0]         nbr_count,
  input  logic                   same_cell,
  output logic                   busy,
  output logic                   done,
  output logic                   home_rd_en,
  output logic [IDX_W-1:0]       home_rd_addr,
  input  logic [3*COORD_W-1:0]   home_rd_data,
  output logic                   nbr_rd_en,
  output logic [IDX_W-1:0]       nbr_rd_addr,
  input  logic [3*COORD_W-1:0]   nbr_rd_data,
  output logic                   pair_valid,
  input  logic                   pair_ready,
  output logic [COORD_W-1:0]     x1,
  output logic [COORD_W-1:0]     y1,
  output logic [COORD_W-1:0]     z1,
  output logic [COORD_W-1:0]     x2,
  output logic [COORD_W-1:0]     y2,
  output logic [COORD_W-1:0]     z2,
  output logic [IDX_W-1:0]       home_idx,
  output logic [IDX_W-1:0]       nbr_idx
);

  // state     | meaning
  // IDLE      | waiting for start
  // HOME_RD   | home cache read of particle i
  // HOME_WAIT | capture home position, set inner start j
  // STREAM    | issue neighbour reads while credit allows
  // NEXT_HOME | advance i
  // DRAIN     | wait for in-flight read and FIFO to empty
  // FINISH    | done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_HOME_RD, S_HOME_WAIT, S_STREAM, S_NEXT_HOME, S_DRAIN, S_FINISH
  } state_t;

  localparam logic [IDX_W:0] ONE = 1;

  state_t                r_state, w_state_nxt;
  logic [IDX_W:0]        r_home_cnt, r_nbr_cnt, r_i, r_j;
  logic                  r_same;
  logic [3*COORD_W-1:0]  r_home_reg;
  logic                  r_inflight;
  logic [IDX_W-1:0]      r_inf_i, r_inf_j;
  logic [3*COORD_W-1:0]  r_fifo_home [2];
  logic [3*COORD_W-1:0]  r_fifo_nbr  [2];
  logic [IDX_W-1:0]      r_fifo_i    [2];
  logic [IDX_W-1:0]      r_fifo_j    [2];
  logic                  r_wptr, r_rptr;
  logic [1:0]            r_occ;

  logic                  w_empty, w_valid, w_pop, w_push, w_fifo_pop, w_credit, w_issue;
  logic                  w_zero_job;
  logic [IDX_W:0]        w_j_init, w_j_inc, w_i_inc;
  logic [3*COORD_W-1:0]  w_head_home, w_head_nbr;
  logic [IDX_W-1:0]      w_head_i, w_head_j;

  assign w_empty    = (r_occ == 2'd0);
  assign w_valid    = !w_empty || r_inflight;
  assign w_pop      = w_valid && pair_ready;
  assign w_fifo_pop = !w_empty && pair_ready;
  // A returning read bypasses the FIFO when it is empty and the bank is ready.
  assign w_push     = r_inflight && !(w_empty && pair_ready);
  assign w_credit   = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
  assign w_issue    = (r_state == S_STREAM) && w_credit;

  assign w_j_inc    = r_j + ONE;
  assign w_i_inc    = r_i + ONE;
  assign w_j_init   = r_same ? w_i_inc : '0;
  assign w_zero_job = (home_count == '0) || (nbr_count == '0) ||
                      (same_cell && (home_count < 2));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (start) w_state_nxt = w_zero_job ? S_FINISH : S_HOME_RD;
      S_HOME_RD:   w_state_nxt = S_HOME_WAIT;
      S_HOME_WAIT: w_state_nxt = (w_j_init >= r_nbr_cnt) ? S_NEXT_HOME : S_STREAM;
      S_STREAM:    if (w_issue && (w_j_inc == r_nbr_cnt)) w_state_nxt = S_NEXT_HOME;
      S_NEXT_HOME: w_state_nxt = (w_i_inc == r_home_cnt) ? S_DRAIN : S_HOME_RD;
      S_DRAIN:     if (!r_inflight && w_empty) w_state_nxt = S_FINISH;
      S_FINISH:    w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_home_cnt <= '0;
      r_nbr_cnt  <= '0;
      r_same     <= 1'b0;
      r_i        <= '0;
      r_j        <= '0;
      r_home_reg <= '0;
      r_inflight <= 1'b0;
      r_inf_i    <= '0;
      r_inf_j    <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (start) begin
          r_home_cnt <= home_count;
          r_nbr_cnt  <= nbr_count;
          r_same     <= same_cell;
          r_i        <= '0;
        end
        S_HOME_WAIT: begin
          r_home_reg <= home_rd_data;
          r_j        <= w_j_init;
        end
        S_STREAM:    if (w_issue) r_j <= w_j_inc;
        S_NEXT_HOME: r_i <= w_i_inc;
        default: ;
      endcase
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inf_i <= r_i[IDX_W-1:0];
        r_inf_j <= r_j[IDX_W-1:0];
      end
      if (w_push)     r_wptr <= ~r_wptr;
      if (w_fifo_pop) r_rptr <= ~r_rptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_fifo_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_home[r_wptr] <= r_home_reg;
      r_fifo_nbr[r_wptr]  <= nbr_rd_data;
      r_fifo_i[r_wptr]    <= r_inf_i;
      r_fifo_j[r_wptr]    <= r_inf_j;
    end
  end

  always_comb begin
    w_head_home = r_home_reg;
    w_head_nbr  = nbr_rd_data;
    w_head_i    = r_inf_i;
    w_head_j    = r_inf_j;
    if (!w_empty) begin
      w_head_home = r_fifo_home[r_rptr];
      w_head_nbr  = r_fifo_nbr[r_rptr];
      w_head_i    = r_fifo_i[r_rptr];
      w_head_j    = r_fifo_j[r_rptr];
    end
  end

  assign busy         = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done         = (r_state == S_FINISH);
  assign home_rd_en   = (r_state == S_HOME_RD);
  assign home_rd_addr = r_i[IDX_W-1:0];
  assign nbr_rd_en    = w_issue;
  assign nbr_rd_addr  = r_j[IDX_W-1:0];
  assign pair_valid   = w_valid;
  assign {x1, y1, z1} = w_valid ? w_head_home : '0;
  assign {x2, y2, z2} = w_valid ? w_head_nbr  : '0;
  assign home_idx     = w_valid ? w_head_i : '0;
  assign nbr_idx      = w_valid ? w_head_j : '0;

endmodule

// File: tb/tb_filter_pair_feeder.sv
// Scoreboard bench for filter_pair_feeder: expected pairs are queued at job
// start and popped as the filter bank accepts them.
module tb_filter_pair_feeder;
  localparam int MAXP  = 64;
  localparam int IDX_W = 6;
  localparam int CW    = 16;

  logic              clk = 1'b0, rst = 1'b0, start = 1'b0, same_cell = 1'b0;
  logic [IDX_W:0]    home_count = '0, nbr_count = '0;
  logic              busy, done, home_rd_en, nbr_rd_en, pair_valid;
  logic              pair_ready = 1'b1;
  logic [IDX_W-1:0]  home_rd_addr, nbr_rd_addr, home_idx, nbr_idx;
  logic [3*CW-1:0]   home_rd_data = '0, nbr_rd_data = '0;
  logic [CW-1:0]     x1, y1, z1, x2, y2, z2;

  filter_pair_feeder #(.MAX_PARTICLES(MAXP), .COORD_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .home_count(home_count), .nbr_count(nbr_count),
    .same_cell(same_cell), .busy(busy), .done(done),
    .home_rd_en(home_rd_en), .home_rd_addr(home_rd_addr), .home_rd_data(home_rd_data),
    .nbr_rd_en(nbr_rd_en), .nbr_rd_addr(nbr_rd_addr), .nbr_rd_data(nbr_rd_data),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .x1(x1), .y1(y1), .z1(z1), .x2(x2), .y2(y2), .z2(z2),
    .home_idx(home_idx), .nbr_idx(nbr_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic [3*CW-1:0]  h;
    logic [3*CW-1:0]  n;
  } pair_t;

  logic [3*CW-1:0] home_mem [MAXP];
  logic [3*CW-1:0] nbr_mem  [MAXP];
  pair_t           exp_q [$];

  int checks = 0, errors = 0, cyc = 0, job_t0 = 0;
  int pops, home_reads, nbr_reads, done_count, valid_cycles, busy_cycles;
  int first_valid, last_valid, last_pop_cyc, last_done_cyc, first_home, first_nbr;
  int outstanding = 0;
  logic stall_prev = 1'b0;
  logic [6*CW+2*IDX_W-1:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read cache models: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (home_rd_en) home_rd_data <= home_mem[home_rd_addr];
    if (nbr_rd_en)  nbr_rd_data  <= nbr_mem[nbr_rd_addr];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    pops = 0; home_reads = 0; nbr_reads = 0; done_count = 0; valid_cycles = 0;
    busy_cycles = 0; first_valid = -1; last_valid = -1; last_pop_cyc = -1;
    last_done_cyc = -1; first_home = -1; first_nbr = -1;
  endtask

  task automatic push_exp(input int hc, input int nc, input bit same);
    pair_t e;
    for (int i = 0; i < hc; i++)
      for (int j = (same ? i + 1 : 0); j < nc; j++) begin
        e.i = IDX_W'(i);
        e.j = IDX_W'(j);
        e.h = home_mem[i];
        e.n = nbr_mem[j];
        exp_q.push_back(e);
      end
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, "_valid"}, pair_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_rd_en"}, {home_rd_en, nbr_rd_en}, 2'b00);
    check({tag, "_coords"}, {x1, y1, z1, x2, y2, z2}, '0);
    check({tag, "_tags"}, {home_idx, nbr_idx, home_rd_addr, nbr_rd_addr}, '0);
  endtask

  // Job driver; rs1/rs2 are extra start pulses (relative cycles) while busy.
  task automatic run_job(input int hc, input int nc, input bit same,
                         input int st_lo, input int st_hi, input int rs1, input int rs2);
    int rel;
    clear_stats();
    push_exp(hc, nc, same);
    tick();
    home_count = (IDX_W+1)'(hc);
    nbr_count  = (IDX_W+1)'(nc);
    same_cell  = same;
    start      = 1'b1;
    pair_ready = 1'b1;
    job_t0     = cyc;
    rel        = 0;
    while (done_count == 0 && rel < 400) begin
      tick();
      rel        = cyc - job_t0;
      start      = (rel == rs1) || (rel == rs2);
      pair_ready = !(rel >= st_lo && rel <= st_hi);
    end
    repeat (10) begin
      tick();
      rel        = cyc - job_t0;
      start      = (rel == rs1) || (rel == rs2);
      pair_ready = 1'b1;
    end
    start = 1'b0;
    check("job_done_count", done_count, 1);
    check("job_queue_empty", exp_q.size(), 0);
    check("job_busy_after", busy, 1'b0);
  endtask

  always @(negedge clk) begin
    pair_t e;
    if (!rst) begin
      stall_prev  = 1'b0;
      outstanding = 0;
    end else begin
      if (home_rd_en) begin home_reads++; if (first_home < 0) first_home = cyc; end
      if (nbr_rd_en) begin
        nbr_reads++; outstanding++;
        if (first_nbr < 0) first_nbr = cyc;
      end
      if (busy) busy_cycles++;
      if (done) begin done_count++; last_done_cyc = cyc; end
      if (stall_prev) begin
        check("hold_valid", pair_valid, 1'b1);
        check("hold_data", {x1, y1, z1, x2, y2, z2, home_idx, nbr_idx}, held);
      end
      if (pair_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
      end
      if (pair_valid && pair_ready) begin
        pops++; last_pop_cyc = cyc; outstanding--;
        check("pair_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pair_tag", {home_idx, nbr_idx}, {e.i, e.j});
          check("pair_home_xyz", {x1, y1, z1}, e.h);
          check("pair_nbr_xyz", {x2, y2, z2}, e.n);
        end
      end
      if (nbr_rd_en) check("outstanding_le2", outstanding <= 2, 1'b1);
      stall_prev = pair_valid && !pair_ready;
      held       = {x1, y1, z1, x2, y2, z2, home_idx, nbr_idx};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < MAXP; k++) begin
      home_mem[k] = {CW'(16'h1000 + k), CW'(16'h2100 + 3 * k), CW'(16'h3200 + 5 * k)};
      nbr_mem[k]  = {CW'(16'h4000 + 7 * k), CW'(16'h5000 + 11 * k), CW'(16'h6000 + 13 * k)};
    end
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    tick();
    rst = 1'b1;

    // 2x3 different cells, bank always ready
    run_job(2, 3, 0, 1000, 1000, -1, -1);
    check("A_pairs", pops, 6);
    check("A_home_rd_lat", first_home - job_t0, 1);
    check("A_nbr_rd_lat", first_nbr - job_t0, 3);
    check("A_valid_lat", first_valid - job_t0, 4);
    check("A_done_after_pop", last_done_cyc > last_pop_cyc, 1'b1);

    // same cell 3x3: half shell only
    run_job(3, 3, 1, 1000, 1000, -1, -1);
    check("B_pairs", pops, 3);
    check("B_nbr_reads", nbr_reads, 3);
    check("B_home_reads", home_reads, 3);

    // empty home cell
    run_job(0, 5, 0, 1000, 1000, -1, -1);
    check("C_reads", home_reads + nbr_reads, 0);
    check("C_valid_cycles", valid_cycles, 0);
    check("C_busy_cycles", busy_cycles, 0);
    check("C_done_lat", last_done_cyc - job_t0, 1);

    // 1x8 streaming, no gaps
    run_job(1, 8, 0, 1000, 1000, -1, -1);
    check("D_pairs", pops, 8);
    check("D_valid_cycles", valid_cycles, 8);
    check("D_valid_span", last_valid - first_valid + 1, 8);

    // 1x8 with backpressure over the 2nd..6th valid cycles
    run_job(1, 8, 0, 5, 9, -1, -1);
    check("E_pairs", pops, 8);
    check("E_nbr_reads", nbr_reads, 8);

    // reset mid-job after three pairs accepted
    clear_stats();
    push_exp(1, 8, 0);
    tick();
    home_count = 7'd1; nbr_count = 7'd8; same_cell = 1'b0; start = 1'b1; pair_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40 && pops < 3; k++) tick();
    check("R_pops_before_rst", pops, 3);
    rst = 1'b0;
    #1;
    chk_quiet("R_async");
    exp_q.delete();
    repeat (3) tick();
    check("R_no_done", done_count, 0);
    rst = 1'b1;
    run_job(2, 3, 0, 1000, 1000, -1, -1);
    check("R_rerun_pairs", pops, 6);

    // start pulses while busy and in the done cycle are ignored
    run_job(2, 3, 0, 1000, 1000, 5, 14);
    check("S_pairs", pops, 6);
    check("S_home_reads", home_reads, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
